alu_ctrl_decoder: RTL and testbench
===================================

Name: alu_ctrl_decoder

Overview:
- EXECUTE-stage ALU control decoder for the MIPS pipeline.
- Maps the 2-bit main-control ALU operation class plus the R-type 6-bit funct field to the 3-bit ALU select code.
- Output is registered: one-clock latency, aligned with the ID/EX to EX timing.
- Also flags unsupported funct codes.

Parameters:
- ILLEGAL_SELECT, 3'b010: select value driven when the R-type funct is unsupported (defaults to ADD).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  decode request qualifier.
- alu_op  input  2  operation class from main control.
- funct  input  6  instruction bits [5:0]; used only when alu_op=2'b10.
- select  output  3  ALU operation select, registered.
- out_valid  output  1  in_valid delayed by one cycle.
- illegal  output  1  registered flag: R-type with unsupported funct.

Behaviour:
- Select encoding, defined as localparams in the package:
  - AND=3'b000, OR=3'b001, ADD=3'b010, SUB=3'b110, SLT=3'b111.
  - With the optional feature only: XOR=3'b011, NOR=3'b100.
- Combinational decode:
  - alu_op 00 -> ADD (lw/sw address); funct ignored.
  - alu_op 01 -> SUB (beq compare); funct ignored.
  - alu_op 10 -> decode funct:
    - 100000 -> ADD
    - 100010 -> SUB
    - 100100 -> AND
    - 100101 -> OR
    - 101010 -> SLT
    - any other -> ILLEGAL_SELECT with illegal=1.
  - alu_op 11 -> OR (ori class); funct ignored; illegal=0.
  - illegal is 0 for every alu_op other than 10.
- Register stage, on each rising clk edge:
  - rst=1 -> select=3'b000, out_valid=0, illegal=0. This is a synchronous reset and has priority over all other inputs.
  - rst=0, in_valid=1 -> select and illegal load the decode result; out_valid=1.
  - rst=0, in_valid=0 -> out_valid=0; select and illegal hold their previous values (no toggling on idle cycles).
- Latency: exactly 1 cycle from the in_valid edge to out_valid/select.
- Throughput: 1 decode per cycle; no backpressure.
- rst asserted in the same cycle as in_valid: the reset wins and the request is dropped.
- X/Z on funct while alu_op≠10 has no effect on the outputs.

Optional Feature:
- Macro: ALU_CTRL_EXT_FUNCT_EN.
- Defined: R-type funct 100110 -> XOR (3'b011) and 100111 -> NOR (3'b100), illegal=0.
- Undefined: both codes are unsupported and produce ILLEGAL_SELECT with illegal=1.

Decomposition:
- Package alu_ctrl_pkg holds:
  - alu_op class constants: ALUOP_MEM=00, ALUOP_BR=01, ALUOP_RTYPE=10, ALUOP_IMM=11.
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_XOR, F_NOR.
  - select constants.
- One natural sub-module: alu_funct_decode, the purely combinational funct -> {select, illegal} map. The top instantiates it and adds the alu_op mux and the output register.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> select=000, out_valid=0, illegal=0.
- alu_op=00, funct=100000, in_valid=1 -> next cycle select=010, out_valid=1. Then alu_op=01 -> select=110.
- alu_op=10, in_valid=1, funct swept back-to-back over 100000, 100010, 100100, 100101, 101010 -> select 010, 110, 000, 001, 111 on consecutive cycles, illegal=0.
- alu_op=10, funct=100111 -> without the macro: select=010, illegal=1; with ALU_CTRL_EXT_FUNCT_EN: select=100, illegal=0.
- Hold: decode SUB, then in_valid=0 for 3 cycles with random funct/alu_op -> select stays 110, out_valid=0.
- alu_op=11, funct=101010 -> select=001, illegal=0. Then rst=1 with in_valid=1 -> select=000 next cycle.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared constants and types for the EX-stage ALU control decoder:
//   - ALUOP_*  : operation class codes from main control
//   - F_*      : R-type funct field codes
//   - SEL_*    : 3-bit ALU select encoding
//   - dec_rsp_t: decode result {sel, illegal}
// Build option: ALU_CTRL_EXT_FUNCT_EN adds the XOR/NOR select codes.
package alu_ctrl_pkg;

  // Operation class from main control
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // R-type funct codes
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;

  // ALU select encoding
  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;
`ifdef ALU_CTRL_EXT_FUNCT_EN
  localparam logic [2:0] SEL_XOR = 3'b011;
  localparam logic [2:0] SEL_NOR = 3'b100;
`endif

  typedef struct packed {
    logic [2:0] sel;
    logic       illegal;
  } dec_rsp_t;

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode
// Purely combinational R-type funct -> {select, illegal} map.
// Ports:
//   funct_i  in  [5:0]      instruction funct field
//   rsp_o    out dec_rsp_t  select code and unsupported-funct flag
// Build option: ALU_CTRL_EXT_FUNCT_EN decodes funct XOR/NOR; otherwise
// those codes fall through to ILLEGAL_SELECT with illegal set.
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter logic [2:0] ILLEGAL_SELECT = 3'b010
) (
  input  logic [5:0] funct_i,
  output dec_rsp_t   rsp_o
);

  always_comb begin
    rsp_o = '{sel: ILLEGAL_SELECT, illegal: 1'b1};
    case (funct_i)
      F_ADD:   rsp_o = '{sel: SEL_ADD, illegal: 1'b0};
      F_SUB:   rsp_o = '{sel: SEL_SUB, illegal: 1'b0};
      F_AND:   rsp_o = '{sel: SEL_AND, illegal: 1'b0};
      F_OR:    rsp_o = '{sel: SEL_OR,  illegal: 1'b0};
      F_SLT:   rsp_o = '{sel: SEL_SLT, illegal: 1'b0};
`ifdef ALU_CTRL_EXT_FUNCT_EN
      F_XOR:   rsp_o = '{sel: SEL_XOR, illegal: 1'b0};
      F_NOR:   rsp_o = '{sel: SEL_NOR, illegal: 1'b0};
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// alu_ctrl_decoder
// EX-stage ALU control decoder: alu_op class + funct -> 3-bit ALU select,
// registered with one cycle of latency.
// Ports:
//   clk        in   system clock (rising edge)
//   rst        in   synchronous active-high reset, highest priority
//   in_valid   in   decode request qualifier
//   alu_op     in   [1:0] operation class from main control
//   funct      in   [5:0] funct field, only consulted for R-type
//   select     out  [2:0] registered ALU select
//   out_valid  out  in_valid delayed one cycle
//   illegal    out  registered unsupported-funct flag
// Build option: ALU_CTRL_EXT_FUNCT_EN (see alu_funct_decode).
module alu_ctrl_decoder
  import alu_ctrl_pkg::*;
#(
  parameter logic [2:0] ILLEGAL_SELECT = 3'b010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] select,
  output logic       out_valid,
  output logic       illegal
);

  dec_rsp_t rtype_rsp;
  dec_rsp_t dec_d, dec_q;
  logic     out_valid_q;

  alu_funct_decode #(.ILLEGAL_SELECT(ILLEGAL_SELECT)) u_funct (
    .funct_i (funct),
    .rsp_o   (rtype_rsp)
  );

  // Non-R-type classes ignore funct entirely, so an X/Z funct cannot
  // leak into select/illegal unless alu_op selects the R-type path.
  always_comb begin
    dec_d = '{sel: SEL_ADD, illegal: 1'b0};
    case (alu_op)
      ALUOP_MEM:   dec_d.sel = SEL_ADD;
      ALUOP_BR:    dec_d.sel = SEL_SUB;
      ALUOP_RTYPE: dec_d     = rtype_rsp;
      ALUOP_IMM:   dec_d.sel = SEL_OR;
      default:     ;
    endcase
  end

  // select/illegal only load on a valid request so idle cycles don't toggle them.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q       <= '{sel: 3'b000, illegal: 1'b0};
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) dec_q <= dec_d;
    end
  end

  assign select    = dec_q.sel;
  assign illegal   = dec_q.illegal;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
module tb_alu_ctrl_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic [2:0] select;
  logic       out_valid;
  logic       illegal;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [2:0] m_sel;
  logic       m_vld;
  logic       m_ill;

  // funct table: code, select, supported
  logic [5:0] tf [7];
  logic [2:0] ts [7];
  logic       tok[7];
  logic       ext;

  always #5 clk = ~clk;

  alu_ctrl_decoder #(.ILLEGAL_SELECT(3'b010)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .alu_op    (alu_op),
    .funct     (funct),
    .select    (select),
    .out_valid (out_valid),
    .illegal   (illegal)
  );

  function automatic void ref_dec(input logic [1:0] op, input logic [5:0] f,
                                  output logic [2:0] s, output logic il);
    s  = 3'b010;
    il = 1'b0;
    if (op == 2'd0)      s = 3'b010;
    else if (op == 2'd1) s = 3'b110;
    else if (op == 2'd3) s = 3'b001;
    else begin
      il = 1'b1;
      for (int i = 0; i < 7; i++)
        if (tok[i] && tf[i] === f) begin
          s  = ts[i];
          il = 1'b0;
        end
    end
  endfunction

  // Advance one clock; model follows the inputs present at the edge.
  task automatic tick();
    logic [2:0] s;
    logic       il;
    ref_dec(alu_op, funct, s, il);
    @(posedge clk);
    if (rst) begin
      m_sel = 3'b000; m_ill = 1'b0; m_vld = 1'b0;
    end else begin
      m_vld = in_valid;
      if (in_valid) begin
        m_sel = s; m_ill = il;
      end
    end
    #1;
  endtask

  task automatic check(input string tag);
    n_cmp++;
    assert (select === m_sel) else begin
      n_err++;
      $error("FAIL %s select got %b want %b", tag, select, m_sel);
    end
    n_cmp++;
    assert (out_valid === m_vld) else begin
      n_err++;
      $error("FAIL %s out_valid got %b want %b", tag, out_valid, m_vld);
    end
    n_cmp++;
    assert (illegal === m_ill) else begin
      n_err++;
      $error("FAIL %s illegal got %b want %b", tag, illegal, m_ill);
    end
  endtask

  task automatic check_sel(input string tag, input logic [2:0] want);
    n_cmp++;
    assert (select === want) else begin
      n_err++;
      $error("FAIL %s select got %b want %b", tag, select, want);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
    in_valid = v; alu_op = op; funct = f;
  endtask

  initial begin
`ifdef ALU_CTRL_EXT_FUNCT_EN
    ext = 1'b1;
`else
    ext = 1'b0;
`endif
    tf  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100110, 6'b100111};
    ts  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b100};
    tok = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ext, ext};

    // reset with a pending request: request dropped
    rst = 1'b1;
    drive(1'b1, 2'b00, 6'b100000);
    tick(); tick();
    check("reset");
    check_sel("reset_sel", 3'b000);
    rst = 1'b0;

    // memory class, then branch class
    drive(1'b1, 2'b00, 6'b100000); tick(); check("mem");
    check_sel("mem_sel", 3'b010);
    drive(1'b1, 2'b01, 6'b111111); tick(); check("br");
    check_sel("br_sel", 3'b110);

    // back-to-back R-type sweep
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b10, tf[i]); tick(); check($sformatf("rtype_%0d", i));
      check_sel($sformatf("rtype_sel_%0d", i), ts[i]);
    end

    // extension codes (supported only with the build option)
    drive(1'b1, 2'b10, 6'b100111); tick(); check("nor");
    check_sel("nor_sel", ext ? 3'b100 : 3'b010);
    drive(1'b1, 2'b10, 6'b100110); tick(); check("xor");
    drive(1'b1, 2'b10, 6'b000000); tick(); check("illegal_000000");

    // hold on idle cycles
    drive(1'b1, 2'b10, 6'b100010); tick(); check("hold_load");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 6'($urandom));
      tick(); check($sformatf("hold_%0d", i));
      check_sel($sformatf("hold_sel_%0d", i), 3'b110);
    end

    // immediate class ignores funct; X funct on non-R-type is harmless
    drive(1'b1, 2'b11, 6'b101010); tick(); check("imm");
    check_sel("imm_sel", 3'b001);
    drive(1'b1, 2'b00, 6'bxxxxxx); tick(); check("x_funct");

    // reset beats a simultaneous request
    rst = 1'b1; drive(1'b1, 2'b01, 6'b0); tick(); check("reset_wins");
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 31) == 0);
      in_valid = 1'($urandom);
      alu_op   = 2'($urandom_range(0, 3));
      funct    = ($urandom_range(0, 1) == 1) ? tf[$urandom_range(0, 6)] : 6'($urandom);
      tick(); check($sformatf("rand_%0d", i));
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
